// File: rtl/pc80_int_ctrl.sv
// rtl/pc80_int_ctrl.sv - uPD8214-style priority interrupt controller (optional PC80_INTC_MODE2_VECTOR_EN)
module pc80_int_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [1:0]         address,
  input  logic [7:0]         writedata,
  output logic [7:0]         readdata,
  input  logic               inta,
  output logic [7:0]         vector,
  output logic               int_req
);

  logic [NUM_SRC-1:0] irq_prev;
  logic [7:0]         pending;
  logic [7:0]         irq_ext;
  logic [7:0]         prev_ext;
  logic [7:0]         edge_set;
  logic [7:0]         clr_mask;
  logic [7:0]         pending_nxt;
  logic [2:0]         h;
  logic [2:0]         level;
  logic               sgs;
  logic               enable;
  logic               any;
  logic               hit;
  logic               wr_ctrl;
  logic               wr_pend;
  logic               rd;
  logic               ack;
  logic               spurious;
  logic [7:0]         ack_vector;
  logic [7:0]         spur_vector;
  logic [7:0]         rd_addr3;

`ifdef PC80_INTC_MODE2_VECTOR_EN
  logic [7:0]         vec_base;
`endif

  // Zero-extend the request inputs and their history to a fixed 8-bit view
  always_comb begin
    irq_ext  = '0;
    prev_ext = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      irq_ext[i]  = irq_in[i];
      prev_ext[i] = irq_prev[i];
    end
  end

  // Highest pending index; bit 7 wins
  always_comb begin
    h = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) h = 3'(i);
    end
  end

  // Bus decode, acknowledge qualification and pending update
  always_comb begin
    wr_ctrl     = chipselect & ~write_n & (address == 2'd0);
    wr_pend     = chipselect & ~write_n & (address == 2'd1);
    rd          = chipselect & write_n;
    any         = |pending;
    hit         = any & enable & (sgs ? (h >= level) : (h > level));
    ack         = inta & int_req;
    spurious    = inta & ~int_req;
    edge_set    = irq_ext & ~prev_ext;
    clr_mask    = (ack ? (8'b1 << h) : 8'h00) | (wr_pend ? writedata : 8'h00);
    // A new edge overrides any clear landing on the same bit
    pending_nxt = (pending & ~clr_mask) | edge_set;
  end

  // Vector formats and address-3 readback depend on the build
  always_comb begin
`ifdef PC80_INTC_MODE2_VECTOR_EN
    ack_vector  = {vec_base[7:4], h, 1'b0};
    spur_vector = {vec_base[7:4], 4'hE};
    rd_addr3    = vec_base;
`else
    ack_vector  = {2'b11, h, 3'b111};
    spur_vector = 8'hFF;
    rd_addr3    = 8'h00;
`endif
  end

  // Edge history and latched requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_nxt;
    end
  end

  // Control register; a control write re-arms enable even during an acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgs    <= 1'b0;
      level  <= 3'd0;
      enable <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        sgs    <= writedata[3];
        level  <= writedata[2:0];
        enable <= 1'b1;
      end else if (ack) begin
        enable <= 1'b0;
      end
    end
  end

`ifdef PC80_INTC_MODE2_VECTOR_EN
  // Mode-2 vector table base
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_base <= 8'h00;
    end else if (chipselect & ~write_n & (address == 2'd3)) begin
      vec_base <= writedata;
    end
  end
`endif

  // Request to the CPU and the vector byte returned on acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_req <= 1'b0;
      vector  <= 8'hFF;
    end else begin
      int_req <= hit;
      if (ack) begin
        vector <= ack_vector;
      end else if (spurious) begin
        vector <= spur_vector;
      end
    end
  end

  // Registered register readback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 8'h00;
    end else if (rd) begin
      case (address)
        2'd0:    readdata <= {4'b0, sgs, level};
        2'd1:    readdata <= pending;
        2'd2:    readdata <= {enable, int_req, 3'b0, h};
        default: readdata <= rd_addr3;
      endcase
    end
  end

endmodule

// File: tb/tb_pc80_int_ctrl.sv
// tb/tb_pc80_int_ctrl.sv - directed self-checking bench for pc80_int_ctrl
module tb_pc80_int_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic       chipselect;
  logic       write_n;
  logic [1:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       inta;
  logic [7:0] vector;
  logic       int_req;
  logic [7:0] rdv;

  int errors = 0;
  int checks = 0;

  pc80_int_ctrl #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .inta       (inta),
    .vector     (vector),
    .int_req    (int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic ack_pulse();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 8'h00; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 8'h00; inta = 1'b0;
    tick(); tick();
    check("rst_vector", vector, 8'hFF);
    check("rst_int_req", {7'b0, int_req}, 8'h00);
    reset = 1'b0;
    tick();

    // Reset while a request is being driven
    irq_in[2] = 1'b1;
    wr(2'd0, 8'h00);
    tick(); tick();
    check("pre_rst_int_req", {7'b0, int_req}, 8'h01);
    reset = 1'b1;
    #2;
    check("async_rst_int_req", {7'b0, int_req}, 8'h00);
    check("async_rst_vector", vector, 8'hFF);
    irq_in = 8'h00;
    #1 reset = 1'b0;
    rdreg(2'd0, rdv); check("rst_rd_ctrl", rdv, 8'h00);
    rdreg(2'd1, rdv); check("rst_rd_pend", rdv, 8'h00);
    rdreg(2'd2, rdv); check("rst_rd_stat", rdv, 8'h00);

    // Single source latency and RST 2 acknowledge
    wr(2'd0, 8'h00);
    irq_in[2] = 1'b1;
    tick();
    check("lat_n1", {7'b0, int_req}, 8'h00);
    tick();
    check("lat_n2", {7'b0, int_req}, 8'h01);
    ack_pulse();
    check("ack_vec_d7", vector, 8'hD7);
    check("ack_k1_int_req", {7'b0, int_req}, 8'h01);
    tick();
    check("ack_k2_int_req", {7'b0, int_req}, 8'h00);
    rdreg(2'd1, rdv); check("held_no_retrigger", rdv, 8'h00);
    rdreg(2'd2, rdv); check("ack_stat", rdv, 8'h00);
    irq_in = 8'h00;

    // Priority and level compare
    irq_in = 8'hA2;
    tick();
    irq_in = 8'h00;
    wr(2'd0, 8'h05);
    tick();
    check("prio_int_req", {7'b0, int_req}, 8'h01);
    ack_pulse();
    check("prio_vec_rst7", vector, 8'hFF);
    rdreg(2'd1, rdv); check("prio_pend", rdv, 8'h22);
    wr(2'd0, 8'h05);
    tick(); tick();
    check("level_eq_blocks", {7'b0, int_req}, 8'h00);
    wr(2'd0, 8'h0D);
    tick();
    check("sgs_int_req", {7'b0, int_req}, 8'h01);
    ack_pulse();
    check("sgs_vec_rst5", vector, 8'hEF);
    rdreg(2'd0, rdv); check("rd_ctrl", rdv, 8'h0D);
    wr(2'd1, 8'hFF);
    rdreg(2'd1, rdv); check("sw_clear", rdv, 8'h00);

    // Set beats software clear
    irq_in[3] = 1'b1;
    wr(2'd1, 8'h08);
    rdreg(2'd1, rdv); check("set_beats_clear", rdv, 8'h08);
    irq_in = 8'h00;
    wr(2'd1, 8'h08);
    rdreg(2'd1, rdv); check("clear_after", rdv, 8'h00);

    // Spurious acknowledge leaves state alone
    irq_in[4] = 1'b1;
    tick();
    irq_in = 8'h00;
    ack_pulse();
    check("spur_vec", vector, 8'hFF);
    rdreg(2'd1, rdv); check("spur_pend", rdv, 8'h10);
    rdreg(2'd2, rdv); check("spur_stat", rdv, 8'h04);

    // Acknowledge coincident with a control write
    wr(2'd0, 8'h00);
    tick();
    check("coll_int_req", {7'b0, int_req}, 8'h01);
    inta = 1'b1;
    wr(2'd0, 8'h00);
    inta = 1'b0;
    check("coll_vec", vector, 8'hE7);
    rdreg(2'd1, rdv); check("coll_pend", rdv, 8'h00);
    rdreg(2'd2, rdv); check("coll_stat", rdv, 8'h80);

`ifdef PC80_INTC_MODE2_VECTOR_EN
    wr(2'd3, 8'h40);
    rdreg(2'd3, rdv); check("vbase_rd", rdv, 8'h40);
    irq_in[2] = 1'b1;
    tick(); tick();
    check("m2_int_req", {7'b0, int_req}, 8'h01);
    ack_pulse();
    check("m2_vec", vector, 8'h44);
    irq_in = 8'h00;
`else
    wr(2'd3, 8'h55);
    rdreg(2'd3, rdv); check("addr3_rd", rdv, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
